// File: rtl/mc_alu.sv
// mc_alu: registered ALU with 1-cycle logic/arith/shift/compare ops and
// iterative shift-add MULU / restoring DIVU producing a HI:LO pair.
module mc_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [3:0]       aluControl,
    output logic [WIDTH-1:0] aluResult,
    output logic [WIDTH-1:0] aluHi,
    output logic             zeroFlag,
    output logic             overflowFlag,
    output logic             outValid,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SH_W  = $clog2(WIDTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ITER = 1'b1;
    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_DIV  = 2'd1;
    localparam logic [1:0] OP_PASS = 2'd2;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] res_q, res_d, rhi_q, rhi_d;
    logic             ovf_q, ovf_d, vld_q, vld_d;

    logic [WIDTH-1:0] sum, diff, one_res, hi_n, lo_n;
    logic [SH_W-1:0]  sh;
    logic [WIDTH:0]   mul_sum, div_sh, div_df;
    logic             one_ovf, ge;

    assign sh   = srcB[SH_W-1:0];
    assign sum  = srcA + srcB;
    assign diff = srcA - srcB;

    always_comb begin
        one_res = '0;
        case (aluControl)
            4'b0010: one_res = sum;
            4'b0110: one_res = diff;
            4'b0000: one_res = srcA & srcB;
            4'b0001: one_res = srcA | srcB;
            4'b0011: one_res = srcA ^ srcB;
            4'b0100: one_res = ~(srcA | srcB);
            4'b0111: one_res = {{(WIDTH-1){1'b0}}, $signed(srcA) < $signed(srcB)};
            4'b1111: one_res = {{(WIDTH-1){1'b0}}, srcA < srcB};
            4'b1000: one_res = srcA << sh;
            4'b1001: one_res = srcA >> sh;
            4'b1010: one_res = $signed(srcA) >>> sh;
            default: one_res = '0;
        endcase
    end

    assign one_ovf = (aluControl == 4'b0010) ? (srcA[WIDTH-1] == srcB[WIDTH-1]) && (sum[WIDTH-1] != srcA[WIDTH-1]) :
                     (aluControl == 4'b0110) ? (srcA[WIDTH-1] != srcB[WIDTH-1]) && (diff[WIDTH-1] != srcA[WIDTH-1]) :
                     1'b0;

    // MUL: HI:LO shifts right, LO holds the multiplier; DIV: HI is the partial remainder, LO shifts quotient bits in
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign div_sh  = {hi_q, lo_q[WIDTH-1]};
    assign div_df  = div_sh - {1'b0, b_q};
    assign ge      = ~div_df[WIDTH];
    assign hi_n    = (op_q == OP_MUL) ? mul_sum[WIDTH:1] :
                     (op_q == OP_DIV) ? (ge ? div_df[WIDTH-1:0] : div_sh[WIDTH-1:0]) : hi_q;
    assign lo_n    = (op_q == OP_MUL) ? {mul_sum[0], lo_q[WIDTH-1:1]} :
                     (op_q == OP_DIV) ? {lo_q[WIDTH-2:0], ge} : lo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        rhi_d   = rhi_q;
        ovf_d   = ovf_q;
        vld_d   = 1'b0;
        if (state_q == IDLE) begin
            if (inValid && (aluControl == 4'b1100 || aluControl == 4'b1101)) begin
                state_d = ITER;
                b_d     = srcB;
                // Divide by zero is staged as a single pass-through step holding the fixed answer
                if (aluControl == 4'b1101 && srcB == '0) begin
                    op_d  = OP_PASS;
                    cnt_d = CNT_W'(1);
                    hi_d  = srcA;
                    lo_d  = '1;
                end else begin
                    op_d  = aluControl[0] ? OP_DIV : OP_MUL;
                    cnt_d = CNT_W'(WIDTH);
                    hi_d  = '0;
                    lo_d  = srcA;
                end
            end else if (inValid) begin
                res_d = one_res;
                rhi_d = '0;
                ovf_d = one_ovf;
                vld_d = 1'b1;
            end
        end else begin
            hi_d  = hi_n;
            lo_d  = lo_n;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = IDLE;
                res_d   = lo_n;
                rhi_d   = hi_n;
                ovf_d   = 1'b0;
                vld_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
            rhi_q   <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            rhi_q   <= rhi_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
        end
    end

    assign inReady      = (state_q == IDLE);
    assign busy         = ~inReady;
    assign aluResult    = res_q;
    assign aluHi        = rhi_q;
    assign zeroFlag     = (res_q == '0);
    assign overflowFlag = ovf_q;
    assign outValid     = vld_q;
endmodule

// File: tb/tb_mc_alu.sv
// tb_mc_alu: random + directed checks of mc_alu at WIDTH=32 and WIDTH=16
// against a transaction-level arithmetic model.
module tb_mc_alu;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  in_v = '0;
    logic [3:0]  ctl = '0;
    logic [31:0] a = '0, b = '0;
    logic        rdy32, bsy32, z32, o32, v32, rdy16, bsy16, z16, o16, v16;
    logic [31:0] r32, h32;
    logic [15:0] r16, h16;
    int n_cmp = 0, n_err = 0;
    longint unsigned m_res[2], m_hi[2], p_res[2], p_hi[2];
    logic m_ovf[2], m_vld[2];
    int rem[2];
    logic [63:0] c_res, c_hi;
    logic c_ovf, c_z;
    int e, rdy_hi;

    always #5 clk = ~clk;

    mc_alu #(.WIDTH(32)) d32 (
        .clk(clk), .reset_n(reset_n), .inValid(in_v[0]), .inReady(rdy32),
        .srcA(a), .srcB(b), .aluControl(ctl), .aluResult(r32), .aluHi(h32),
        .zeroFlag(z32), .overflowFlag(o32), .outValid(v32), .busy(bsy32)
    );
    mc_alu #(.WIDTH(16)) d16 (
        .clk(clk), .reset_n(reset_n), .inValid(in_v[1]), .inReady(rdy16),
        .srcA(a[15:0]), .srcB(b[15:0]), .aluControl(ctl), .aluResult(r16), .aluHi(h16),
        .zeroFlag(z16), .overflowFlag(o16), .outValid(v16), .busy(bsy16)
    );

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic string nm(input int k, input string n);
        return $sformatf("w%0d %s", k ? 16 : 32, n);
    endfunction

    // Reference semantics from plain integer arithmetic; lat = edges from accept to result
    function automatic void ref_op(input int w, input logic [3:0] c, input longint unsigned x0, y0,
                                   output longint unsigned res, hi, output logic ovf, output int lat);
        longint unsigned m = (64'd1 << w) - 1;
        longint unsigned x = x0 & m, y = y0 & m;
        longint lim = longint'(1) << (w - 1);
        longint sx = (x >> (w - 1)) != 0 ? longint'(x) - (longint'(1) << w) : longint'(x);
        longint sy = (y >> (w - 1)) != 0 ? longint'(y) - (longint'(1) << w) : longint'(y);
        int sh = int'(y % longint'(w));
        longint s;
        res = 0; hi = 0; ovf = 1'b0; lat = 0;
        case (c)
            4'b0010: begin res = (x + y) & m; s = sx + sy; ovf = (s >= lim) || (s < -lim); end
            4'b0110: begin res = (x - y) & m; s = sx - sy; ovf = (s >= lim) || (s < -lim); end
            4'b0000: res = x & y;
            4'b0001: res = x | y;
            4'b0011: res = x ^ y;
            4'b0100: res = ~(x | y) & m;
            4'b0111: res = (sx < sy) ? 1 : 0;
            4'b1111: res = (x < y) ? 1 : 0;
            4'b1000: res = (x << sh) & m;
            4'b1001: res = x >> sh;
            4'b1010: res = longint'(unsigned'(sx >>> sh)) & m;
            4'b1100: begin res = (x * y) & m; hi = (x * y) >> w; lat = w; end
            4'b1101: begin
                if (y == 0) begin res = m; hi = x; lat = 1; end
                else begin res = x / y; hi = x % y; lat = w; end
            end
            default: res = 0;
        endcase
    endfunction

    task automatic step(input int k);
        longint unsigned r, h;
        logic o;
        int l;
        if (!reset_n) begin
            m_res[k] = 0; m_hi[k] = 0; m_ovf[k] = 1'b0; m_vld[k] = 1'b0; rem[k] = 0;
        end else begin
            m_vld[k] = 1'b0;
            if (rem[k] > 0) begin
                rem[k]--;
                if (rem[k] == 0) begin
                    m_res[k] = p_res[k]; m_hi[k] = p_hi[k]; m_ovf[k] = 1'b0; m_vld[k] = 1'b1;
                end
            end else if (in_v[k]) begin
                ref_op(k ? 16 : 32, ctl, a, b, r, h, o, l);
                if (l == 0) begin
                    m_res[k] = r; m_hi[k] = h; m_ovf[k] = o; m_vld[k] = 1'b1;
                end else begin
                    p_res[k] = r; p_hi[k] = h; rem[k] = l;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) step(k);
            @(negedge clk);
            chk(nm(0, "aluResult"), 64'(r32), m_res[0]);
            chk(nm(0, "aluHi"), 64'(h32), m_hi[0]);
            chk(nm(0, "zeroFlag"), 64'(z32), 64'(m_res[0] == 0));
            chk(nm(0, "overflowFlag"), 64'(o32), 64'(m_ovf[0]));
            chk(nm(0, "outValid"), 64'(v32), 64'(m_vld[0]));
            chk(nm(0, "inReady"), 64'(rdy32), 64'(rem[0] == 0));
            chk(nm(0, "busy"), 64'(bsy32), 64'(rem[0] != 0));
            chk(nm(1, "aluResult"), 64'(r16), m_res[1]);
            chk(nm(1, "aluHi"), 64'(h16), m_hi[1]);
            chk(nm(1, "zeroFlag"), 64'(z16), 64'(m_res[1] == 0));
            chk(nm(1, "overflowFlag"), 64'(o16), 64'(m_ovf[1]));
            chk(nm(1, "outValid"), 64'(v16), 64'(m_vld[1]));
            chk(nm(1, "inReady"), 64'(rdy16), 64'(rem[1] == 0));
            chk(nm(1, "busy"), 64'(bsy16), 64'(rem[1] != 0));
        end
    end

    // Called just after a posedge; returns just after the accepting posedge
    task automatic issue(input int k, input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        int t = 0;
        ctl = c; a = x; b = y; in_v[k] = 1'b1;
        @(negedge clk);
        while (rem[k] != 0 && t < 200) begin t++; @(negedge clk); end
        chk(nm(k, "ready before accept"), 64'(rem[k] == 0), 64'd1);
        @(posedge clk); #1;
        in_v[k] = 1'b0;
    endtask

    // e = edges after the accept edge at which outValid rose; outputs captured in c_*
    task automatic run(input int k, input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        issue(k, c, x, y);
        e = 0; rdy_hi = 0;
        @(negedge clk);
        while (!(k ? v16 : v32) && e < 100) begin
            rdy_hi += int'(k ? rdy16 : rdy32);
            e++;
            @(negedge clk);
        end
        c_res = k ? 64'(r16) : 64'(r32);
        c_hi  = k ? 64'(h16) : 64'(h32);
        c_ovf = k ? o16 : o32;
        c_z   = k ? z16 : z32;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("reset aluResult", 64'(r32), 64'h0);
        chk("reset zeroFlag", 64'(z32), 64'h1);
        chk("reset outValid", 64'(v32), 64'h0);
        chk("reset inReady", 64'(rdy32), 64'h1);
        @(posedge clk); #1;
        run(0, 4'b0010, 32'h7FFF_FFFF, 32'h1);
        chk("add latency", 64'(e), 64'd0);
        chk("add result", c_res, 64'h8000_0000);
        chk("add overflow", 64'(c_ovf), 64'h1);
        chk("add zero", 64'(c_z), 64'h0);
        ctl = 4'b0110; a = 32'd5; b = 32'd5; in_v[0] = 1'b1;
        @(posedge clk); #1;
        ctl = 4'b0111; a = 32'hFFFF_FFFF; b = 32'd1;
        @(negedge clk);
        chk("sub zero", 64'(z32), 64'h1);
        chk("sub valid", 64'(v32), 64'h1);
        @(posedge clk); #1;
        ctl = 4'b1111;
        @(negedge clk);
        chk("slt result", 64'(r32), 64'h1);
        chk("slt valid", 64'(v32), 64'h1);
        @(posedge clk); #1;
        in_v[0] = 1'b0;
        @(negedge clk);
        chk("sltu result", 64'(r32), 64'h0);
        chk("sltu valid", 64'(v32), 64'h1);
        @(posedge clk); #1;
        run(0, 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mulu latency", 64'(e), 64'd32);
        chk("mulu lo", c_res, 64'h1);
        chk("mulu hi", c_hi, 64'hFFFF_FFFE);
        chk("mulu ready low", 64'(rdy_hi), 64'd0);
        run(0, 4'b1101, 32'd100, 32'd7);
        chk("divu latency", 64'(e), 64'd32);
        chk("divu quotient", c_res, 64'd14);
        chk("divu remainder", c_hi, 64'd2);
        run(0, 4'b1101, 32'd9, 32'd0);
        chk("div0 latency", 64'(e), 64'd1);
        chk("div0 lo", c_res, 64'hFFFF_FFFF);
        chk("div0 hi", c_hi, 64'd9);
        issue(0, 4'b1100, 32'h0012_3456, 32'd789);
        repeat (10) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        chk("abort aluResult", 64'(r32), 64'h0);
        chk("abort aluHi", 64'(h32), 64'h0);
        chk("abort zeroFlag", 64'(z32), 64'h1);
        chk("abort outValid", 64'(v32), 64'h0);
        chk("abort inReady", 64'(rdy32), 64'h1);
        @(posedge clk); #1;
        run(0, 4'b0010, 32'd3, 32'd4);
        chk("post-abort add latency", 64'(e), 64'd0);
        chk("post-abort add", c_res, 64'd7);
        run(0, 4'b1010, 32'h8000_0000, 32'd31);
        chk("sra32", c_res, 64'hFFFF_FFFF);
        run(0, 4'b1001, 32'h8000_0000, 32'd31);
        chk("srl32", c_res, 64'h1);
        run(0, 4'b1110, 32'h1234_5678, 32'd1);
        chk("unknown32 lo", c_res, 64'h0);
        chk("unknown32 hi", c_hi, 64'h0);
        run(1, 4'b1010, 32'h8000, 32'd15);
        chk("sra16", c_res, 64'hFFFF);
        run(1, 4'b1001, 32'h8000, 32'd15);
        chk("srl16", c_res, 64'h1);
        run(1, 4'b1110, 32'h1234, 32'd1);
        chk("unknown16", c_res, 64'h0);
        run(1, 4'b1100, 32'hFFFF, 32'hFFFF);
        chk("mulu16 latency", 64'(e), 64'd16);
        chk("mulu16 lo", c_res, 64'h1);
        chk("mulu16 hi", c_hi, 64'hFFFE);
        run(1, 4'b1101, 32'd100, 32'd7);
        chk("divu16 quotient", c_res, 64'd14);
        chk("divu16 remainder", c_hi, 64'd2);
        for (int k = 0; k < 2; k++) begin
            repeat (150) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                issue(k, 4'($urandom_range(0, 15)), rv(), rv());
            end
        end
        repeat (40) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
